// File: rtl/gpc_cam_pkg.sv
// Shared helpers for the one-hot CAM: index width derivation, multi-match
// detection and lowest-match priority encoding.
package gpc_cam_pkg;

  // Widest match vector the helpers accept; callers zero-extend into this.
  localparam int MAX_KEYS = 64;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic popcnt_ge2(input logic [MAX_KEYS-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return multi;
  endfunction

  function automatic int lowest_set_index(input logic [MAX_KEYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cam_match_array.sv
// Combinational key compare across all table entries; produces the match
// vector plus hit / multi-hit / lowest-index summaries. Holds no state.
module cam_match_array
  import gpc_cam_pkg::*;
#(
  parameter int NR_KEY    = 4,
  parameter int KEY_WIDTH = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NR_KEY-1:0][KEY_WIDTH-1:0] keys,
  input  logic [NR_KEY-1:0]                valid,
  input  logic [KEY_WIDTH-1:0]             req_key,
  output logic [NR_KEY-1:0]                match,
  output logic                             hit,
  output logic                             multi,
  output logic [IDX_W-1:0]                 index
);

  logic [MAX_KEYS-1:0] match_ext;

  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = valid[i] && (keys[i] == req_key);
    end
  end

  // NR_KEY must not exceed MAX_KEYS; the helpers work on the widened vector.
  assign match_ext = MAX_KEYS'(match);
  assign hit       = |match;
  assign multi     = popcnt_ge2(match_ext);
  assign index     = IDX_W'(lowest_set_index(match_ext));

endmodule

// File: rtl/onehot_cam.sv
// Programmable key-to-one-hot lookup: table registers, a one-deep response
// register with valid/ready flow control, and a saturating hit counter.
module onehot_cam
  import gpc_cam_pkg::*;
#(
  parameter int  NR_KEY    = 4,
  parameter int  KEY_WIDTH = 4,
  parameter int  CNT_WIDTH = 8,
  localparam int IDX_W     = clog2_min1(NR_KEY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [KEY_WIDTH-1:0] wr_key,
  input  logic                 wr_set,
  input  logic                 clr_all,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_WIDTH-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NR_KEY-1:0]    rsp_onehot,
  output logic [IDX_W-1:0]     rsp_index,
  output logic                 rsp_hit,
  output logic                 rsp_multi,
  output logic [CNT_WIDTH-1:0] hit_cnt
);

  logic [NR_KEY-1:0][KEY_WIDTH-1:0] keys;
  logic [NR_KEY-1:0]                valid;
  logic [NR_KEY-1:0]                match;
  logic                             hit;
  logic                             multi;
  logic [IDX_W-1:0]                 index;
  logic                             accept;

  cam_match_array #(
    .NR_KEY   (NR_KEY),
    .KEY_WIDTH(KEY_WIDTH),
    .IDX_W    (IDX_W)
  ) u_match (
    .keys   (keys),
    .valid  (valid),
    .req_key(req_key),
    .match  (match),
    .hit    (hit),
    .multi  (multi),
    .index  (index)
  );

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Key storage is don't-care until its valid bit is set, so it has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) keys[i] <= wr_key;
    end
  end

  // Clear first, then the write; the later assignment wins for that entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (clr_all) valid <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) valid[i] <= wr_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_onehot <= '0;
      rsp_index  <= '0;
      rsp_hit    <= 1'b0;
      rsp_multi  <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_onehot <= match;
      rsp_index  <= index;
      rsp_hit    <= hit;
      rsp_multi  <= multi;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule
